// File: rtl/attest_checker.sv
// attest_checker: execution-trace attestation table.
//   An 8192 x 1 bit table indexed by a 13-bit trace hash. LEARN hashes set their bit,
//   CHECK hashes test it and record misses as violations. After reset or a clear
//   request, the table is swept to zero one address per cycle while busy is high.
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   hash_valid          one-cycle qualifier for hash_value / mode
//   hash_value[12:0]    table index
//   mode[1:0]           01 LEARN, 10 CHECK, 00/11 ignored
//   clear_req           wipe table and statistics (honoured only outside the sweep)
//   busy                table sweep in progress
//   result_valid        one pulse per processed LEARN/CHECK, 2 cycles after acceptance
//   result_hit          table bit seen by that hash before any update
//   violation           sticky, set by the first CHECK miss
//   viol_count[15:0]    saturating CHECK-miss count
//   first_viol_hash     hash of the first CHECK miss since the last clear
//   learned_count[13:0] number of table bits set
//   dropped             sticky, a hash arrived while busy; only reset clears it
module attest_checker (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hash_valid,
    input  logic [12:0] hash_value,
    input  logic [1:0]  mode,
    input  logic        clear_req,
    output logic        busy,
    output logic        result_valid,
    output logic        result_hit,
    output logic        violation,
    output logic [15:0] viol_count,
    output logic [12:0] first_viol_hash,
    output logic [13:0] learned_count,
    output logic        dropped
);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [12:0] LAST_ADDR   = 13'h1FFF;
    localparam logic [1:0]  MODE_LEARN  = 2'b01;
    localparam logic [1:0]  MODE_CHECK  = 2'b10;
    localparam logic [15:0] VIOL_MAX    = 16'hFFFF;
    localparam logic [13:0] LEARNED_MAX = 14'd8192;

    state_t      state_r, state_next_s;
    logic        busy_r, busy_next_s;
    logic [12:0] sweep_addr_r, sweep_addr_next_s;

    logic        s1_valid_r, s1_learn_r;
    logic [12:0] s1_hash_r;
    logic        s2_valid_r, s2_learn_r, s2_fwd_r;
    logic [12:0] s2_hash_r;
    logic        rd_bit_r;

    logic        result_valid_r, result_hit_r, violation_r, dropped_r;
    logic [15:0] viol_count_r;
    logic [12:0] first_viol_hash_r;
    logic [13:0] learned_count_r;

    logic        table_r [0:8191];

    logic        accept_s, run_clear_s, s2_bit_s, miss_s, learn_set_s;
    logic        mem_we_s, mem_wdata_s;
    logic [12:0] mem_waddr_s;

    // Hashes are taken only in RUN; a clear request flushes the cycle it arrives in.
    assign accept_s    = hash_valid && (state_r == ST_RUN) && !clear_req &&
                         ((mode == MODE_LEARN) || (mode == MODE_CHECK));
    assign run_clear_s = (state_r == ST_RUN) && clear_req;
    // A LEARN retiring on the same edge the next hash read the table is not yet in
    // the RAM output, so its effect is forwarded.
    assign s2_bit_s    = rd_bit_r | s2_fwd_r;
    assign miss_s      = s2_valid_r && !s2_learn_r && !s2_bit_s;
    assign learn_set_s = s2_valid_r && s2_learn_r && !s2_bit_s;

    // Next-state logic for the sweep FSM. The first CLEAR cycle after reset only
    // raises busy, so busy spans exactly the 8192 write cycles that follow.
    always_comb begin
        state_next_s      = state_r;
        busy_next_s       = busy_r;
        sweep_addr_next_s = sweep_addr_r;
        case (state_r)
            ST_CLEAR: begin
                busy_next_s = 1'b1;
                if (busy_r) begin
                    if (sweep_addr_r == LAST_ADDR) begin
                        state_next_s      = ST_RUN;
                        busy_next_s       = 1'b0;
                        sweep_addr_next_s = 13'd0;
                    end else begin
                        sweep_addr_next_s = sweep_addr_r + 13'd1;
                    end
                end else begin
                    sweep_addr_next_s = 13'd0;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_next_s      = ST_CLEAR;
                    busy_next_s       = 1'b1;
                    sweep_addr_next_s = 13'd0;
                end else begin
                    busy_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s      = ST_CLEAR;
                busy_next_s       = 1'b0;
                sweep_addr_next_s = 13'd0;
            end
        endcase
    end

    // FSM state, busy flag and sweep address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_CLEAR;
            busy_r       <= 1'b0;
            sweep_addr_r <= 13'd0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= busy_next_s;
            sweep_addr_r <= sweep_addr_next_s;
        end
    end

    // Single table write port: sweep zeros during CLEAR, LEARN sets in RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = 13'd0;
        mem_wdata_s = 1'b0;
        if ((state_r == ST_CLEAR) && busy_r) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = sweep_addr_r;
            mem_wdata_s = 1'b0;
        end else if (learn_set_s && !run_clear_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = s2_hash_r;
            mem_wdata_s = 1'b1;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Table RAM with registered read of the stage-1 hash (no reset on storage).
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            table_r[mem_waddr_s] <= mem_wdata_s;
        end
        rd_bit_r <= table_r[s1_hash_r];
    end

    // Hash pipeline, result outputs and statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r        <= 1'b0;
            s1_learn_r        <= 1'b0;
            s1_hash_r         <= 13'd0;
            s2_valid_r        <= 1'b0;
            s2_learn_r        <= 1'b0;
            s2_hash_r         <= 13'd0;
            s2_fwd_r          <= 1'b0;
            result_valid_r    <= 1'b0;
            result_hit_r      <= 1'b0;
            violation_r       <= 1'b0;
            viol_count_r      <= 16'd0;
            first_viol_hash_r <= 13'd0;
            learned_count_r   <= 14'd0;
        end else if (run_clear_s) begin
            s1_valid_r        <= 1'b0;
            s2_valid_r        <= 1'b0;
            s2_fwd_r          <= 1'b0;
            result_valid_r    <= 1'b0;
            result_hit_r      <= 1'b0;
            violation_r       <= 1'b0;
            viol_count_r      <= 16'd0;
            first_viol_hash_r <= 13'd0;
            learned_count_r   <= 14'd0;
        end else begin
            s1_valid_r     <= accept_s;
            s1_learn_r     <= (mode == MODE_LEARN);
            s1_hash_r      <= hash_value;
            s2_valid_r     <= s1_valid_r;
            s2_learn_r     <= s1_learn_r;
            s2_hash_r      <= s1_hash_r;
            s2_fwd_r       <= s1_valid_r && s2_valid_r && s2_learn_r && (s2_hash_r == s1_hash_r);
            result_valid_r <= s2_valid_r;
            result_hit_r   <= s2_valid_r && s2_bit_s;
            if (miss_s) begin
                violation_r <= 1'b1;
                if (viol_count_r != VIOL_MAX) begin
                    viol_count_r <= viol_count_r + 16'd1;
                end
                if (!violation_r) begin
                    first_viol_hash_r <= s2_hash_r;
                end
            end
            if (learn_set_s && (learned_count_r != LEARNED_MAX)) begin
                learned_count_r <= learned_count_r + 14'd1;
            end
        end
    end

    // Sticky drop flag: survives clear_req, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropped_r <= 1'b0;
        end else if (hash_valid && busy_r) begin
            dropped_r <= 1'b1;
        end else begin
            dropped_r <= dropped_r;
        end
    end

    assign busy            = busy_r;
    assign result_valid    = result_valid_r;
    assign result_hit      = result_hit_r;
    assign violation       = violation_r;
    assign viol_count      = viol_count_r;
    assign first_viol_hash = first_viol_hash_r;
    assign learned_count   = learned_count_r;
    assign dropped         = dropped_r;

endmodule

// File: doc/attest_checker.md
ATTEST_CHECKER -- requirements
Module: attest_checker

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-002 hash_valid  input  1  one-cycle qualifier for hash_value from the upstream hash stage.
REQ-003 hash_value  input  13  trace hash, table index 0..8191.
REQ-004 mode  input  2  sampled with hash_valid: 00 ignore, 01 LEARN, 10 CHECK, 11 ignore.
REQ-005 clear_req  input  1  single-cycle request to wipe the table and statistics.
REQ-006 busy  output  1  high while the table is being cleared.
REQ-007 result_valid  output  1  one-cycle pulse per processed LEARN/CHECK hash.
REQ-008 result_hit  output  1  table bit value seen by that hash before any update.
REQ-009 violation  output  1  sticky; set by first CHECK miss.
REQ-010 viol_count  output  16  saturating count of CHECK misses.
REQ-011 first_viol_hash  output  13  hash_value of first CHECK miss since last clear.
REQ-012 learned_count  output  14  number of table bits set, 0..8192.
REQ-013 dropped  output  1  sticky; a hash_valid arrived while busy.

Function
REQ-014 Table SHALL be 8192 x 1 bit, synchronous read, one write port, contents undefined until cleared.
REQ-015 FSM states SHALL be CLEAR and RUN; reset exit -> CLEAR.
REQ-016 CLEAR: write 0 to address 0,1,...,8191, one per cycle; after address 8191 -> RUN; busy=1 for exactly 8192 cycles.
REQ-017 Entering CLEAR SHALL zero violation, viol_count, first_viol_hash, learned_count; dropped SHALL NOT be cleared by clear_req, only by reset.
REQ-018 clear_req in RUN SHALL enter CLEAR next cycle, discarding any in-flight hash (no result_valid); clear_req during CLEAR ignored (no restart).
REQ-019 hash_valid with busy=1 SHALL be discarded and set dropped; hash_valid with mode 00/11 SHALL be discarded silently.
REQ-020 Pipeline: hash accepted at edge E0 (read issued), table bit registered at E1, result_valid/result_hit/counters updated at E2; latency exactly 2 cycles; throughput one hash per cycle, no backpressure.
REQ-021 LEARN: if bit=0, write 1 and increment learned_count; result_hit = prior bit; never affects violation stats.
REQ-022 CHECK: no write; result_hit = bit; on miss set violation, viol_count += 1 saturating at 0xFFFF, capture first_viol_hash only if violation was 0.
REQ-023 Read-after-write: a hash SHALL observe every write from earlier accepted hashes, including back-to-back same address (forwarding required); learned_count SHALL never double-count.
REQ-024 learned_count SHALL not exceed 8192.

Reset
REQ-025 reset_n low SHALL asynchronously force busy=0, result_valid=0, result_hit=0, violation=0, viol_count=0, first_viol_hash=0, learned_count=0, dropped=0, pipeline empty, FSM to CLEAR with sweep address 0; busy=1 from first edge after reset_n release.
REQ-026 Reset mid-CLEAR or mid-pipeline SHALL restart the sweep from address 0; no partial result emitted.

Verification
REQ-027 Release reset; drive hash_valid at sweep cycle 100 -> busy high exactly 8192 cycles, no result_valid, dropped=1.
REQ-028 RUN, LEARN 0x0ABC on two consecutive cycles -> results hit=0 then hit=1, learned_count=1.
REQ-029 CHECK 0x0ABC, 0x1FFF, 0x0001 back-to-back -> hits 1,0,0; violation=1, viol_count=2, first_viol_hash=0x1FFF.
REQ-030 65537 CHECK misses -> viol_count stays 0xFFFF, violation=1.
REQ-031 After learning 0x0ABC, pulse clear_req with a hash in flight -> no result for it, busy 8192 cycles, counters 0, dropped unchanged; CHECK 0x0ABC -> hit=0.
REQ-032 Assert reset_n low at sweep address 4000 -> outputs zero immediately; after release busy lasts full 8192 cycles.
